// File: rtl/manchester_tx_pkg.sv
// Shared definitions for the Manchester transmitter: FSM state encoding,
// minimum half-bit length and the effective-H helper.
// Optional feature macro: MANCHESTER_TX_PARITY_EN adds the PARITY state.
package manchester_tx_pkg;

  // Shortest legal half-bit in clocks; smaller requests are raised to this.
  localparam int unsigned MIN_HALF = 2;

`ifdef MANCHESTER_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;
`endif

  // Half-bit length actually used for a requested value.
  function automatic int unsigned eff_half(input int unsigned h);
    return (h < MIN_HALF) ? MIN_HALF : h;
  endfunction

endpackage

// File: rtl/manchester_tx_if.sv
// Payload handshake channel of the Manchester transmitter.
// master: payload source; slave: transmitter.
interface manchester_tx_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REF_W  = 4
);
  logic [REF_W-1:0]  halfPeriod;
  logic [DATA_W-1:0] txData;
  logic              txValid;
  logic              txReady;

  modport master (output halfPeriod, output txData, output txValid, input txReady);
  modport slave  (input halfPeriod, input txData, input txValid, output txReady);
endinterface

// File: rtl/manchester_halfbit_timer.sv
// Half-bit timer: captures the effective H on load, then counts down and
// flags the last cycle of every half-bit (halfEnd) and the cycle before it
// (halfNear), reloading automatically while running.
module manchester_halfbit_timer
  import manchester_tx_pkg::*;
#(
  parameter int unsigned REF_W = 4
) (
  input  logic             clk,
  input  logic             globalReset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [REF_W-1:0] i_halfPeriod,
  output logic             o_halfEnd,
  output logic             o_halfNear
);

  localparam logic [REF_W-1:0] ONE = REF_W'(1);

  logic [REF_W-1:0] r_h;
  logic [REF_W-1:0] r_cnt;
  logic [REF_W-1:0] w_hEff;

  assign w_hEff = REF_W'(eff_half(32'(i_halfPeriod)));

  // Load on accept, otherwise count down and reload at the end of each half.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_h   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_h   <= w_hEff;
      r_cnt <= w_hEff - ONE;
    end else if (i_run) begin
      if (r_cnt == '0) r_cnt <= r_h - ONE;
      else             r_cnt <= r_cnt - ONE;
    end
  end

  assign o_halfEnd  = i_run && (r_cnt == '0);
  assign o_halfNear = i_run && (r_cnt == ONE);

endmodule

// File: rtl/manchester_tx.sv
// Manchester transmitter: one low-high sync bit, DATA_W payload bits MSB
// first (0 = low/high, 1 = high/low), optional even-parity bit, then a
// forced-low gap of IDLE_BITS bit-times ending with a frameDone pulse.
// Optional feature macro: MANCHESTER_TX_PARITY_EN.
module manchester_tx
  import manchester_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REF_W     = 4,
  parameter int unsigned IDLE_BITS = 2
) (
  input  logic            clk,
  input  logic            globalReset,
  manchester_tx_if.slave  tx,
  output logic            manOut,
  output logic            busy,
  output logic            frameDone
);

  localparam int unsigned BIT_W      = $clog2(DATA_W + 1);
  localparam int unsigned GAP_HALVES = 2 * IDLE_BITS;
  localparam int unsigned GAP_W      = $clog2(GAP_HALVES + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_HALVES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  tx_state_e         r_state;
  logic              r_manOut;
  logic              r_busy;
  logic              r_frameDone;
  logic              r_half;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bitCnt;
  logic [GAP_W-1:0]  r_gapCnt;
`ifdef MANCHESTER_TX_PARITY_EN
  logic              r_parity;
`endif

  logic [DATA_W-1:0] w_shiftNext;
  logic              w_accept;
  logic              w_halfEnd;
  logic              w_halfNear;

  // Ready is the IDLE state masked by reset, so it is low throughout reset
  // yet already high in the first cycle after reset is released.
  assign tx.txReady  = (r_state == ST_IDLE) && !globalReset;
  assign w_accept    = tx.txValid && tx.txReady;
  assign w_shiftNext = r_shift << 1;

  manchester_halfbit_timer #(
    .REF_W (REF_W)
  ) u_timer (
    .clk          (clk),
    .globalReset  (globalReset),
    .i_load       (w_accept),
    .i_run        (r_busy),
    .i_halfPeriod (tx.halfPeriod),
    .o_halfEnd    (w_halfEnd),
    .o_halfNear   (w_halfNear)
  );

  // Frame sequencer with registered line, busy and frameDone outputs.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      r_state     <= ST_IDLE;
      r_manOut    <= 1'b0;
      r_busy      <= 1'b0;
      r_frameDone <= 1'b0;
      r_half      <= 1'b0;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_gapCnt    <= '0;
`ifdef MANCHESTER_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_manOut <= 1'b0;
          r_busy   <= 1'b0;
          r_half   <= 1'b0;
          if (w_accept) begin
            r_state  <= ST_SYNC;
            r_busy   <= 1'b1;
            r_shift  <= tx.txData;
            r_bitCnt <= '0;
`ifdef MANCHESTER_TX_PARITY_EN
            r_parity <= ^tx.txData;
`endif
          end
        end

        ST_SYNC: begin
          if (w_halfEnd) begin
            if (!r_half) begin
              r_half   <= 1'b1;
              r_manOut <= 1'b1;
            end else begin
              r_half   <= 1'b0;
              r_manOut <= r_shift[DATA_W-1];
              r_state  <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_halfEnd) begin
            if (!r_half) begin
              r_half   <= 1'b1;
              r_manOut <= ~r_shift[DATA_W-1];
            end else begin
              r_half <= 1'b0;
              if (r_bitCnt == LAST_BIT) begin
`ifdef MANCHESTER_TX_PARITY_EN
                r_state  <= ST_PARITY;
                r_manOut <= r_parity;
`else
                r_state  <= ST_GAP;
                r_manOut <= 1'b0;
                r_gapCnt <= '0;
`endif
              end else begin
                r_shift  <= w_shiftNext;
                r_bitCnt <= r_bitCnt + BIT_ONE;
                r_manOut <= w_shiftNext[DATA_W-1];
              end
            end
          end
        end

`ifdef MANCHESTER_TX_PARITY_EN
        ST_PARITY: begin
          if (w_halfEnd) begin
            if (!r_half) begin
              r_half   <= 1'b1;
              r_manOut <= ~r_parity;
            end else begin
              r_half   <= 1'b0;
              r_state  <= ST_GAP;
              r_manOut <= 1'b0;
              r_gapCnt <= '0;
            end
          end
        end
`endif

        ST_GAP: begin
          r_manOut <= 1'b0;
          // Raised one cycle early so the registered pulse lands on the
          // final gap cycle.
          if (w_halfNear && (r_gapCnt == LAST_GAP)) r_frameDone <= 1'b1;
          if (w_halfEnd) begin
            if (r_gapCnt == LAST_GAP) begin
              r_state  <= ST_IDLE;
              r_busy   <= 1'b0;
              r_gapCnt <= '0;
            end else begin
              r_gapCnt <= r_gapCnt + GAP_ONE;
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_manOut <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign manOut    = r_manOut;
  assign busy      = r_busy;
  assign frameDone = r_frameDone;

endmodule

// File: tb/tb_manchester_tx.sv
// Scoreboard bench for manchester_tx: a predictor expands every accepted
// payload into the expected per-cycle line waveform; a monitor compares the
// DUT outputs against it every cycle.
module tb_manchester_tx;

  localparam int DATA_W    = 8;
  localparam int REF_W     = 4;
  localparam int IDLE_BITS = 2;
  localparam int BUDGET    = 2000;

  typedef struct packed {
    logic man;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic clk = 1'b0;
  logic globalReset;
  logic manOut, busy, frameDone;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   accepts     = 0;
  bit   last_was_idle = 1'b0;
  bit   mon_en      = 1'b0;

  manchester_tx_if #(.DATA_W(DATA_W), .REF_W(REF_W)) tx_if ();

  manchester_tx #(
    .DATA_W    (DATA_W),
    .REF_W     (REF_W),
    .IDLE_BITS (IDLE_BITS)
  ) dut (
    .clk         (clk),
    .globalReset (globalReset),
    .tx          (tx_if),
    .manOut      (manOut),
    .busy        (busy),
    .frameDone   (frameDone)
  );

  always #5 clk = ~clk;

  // Expected waveform of one frame: list of half-bit levels, each repeated H times.
  function automatic void push_frame(input logic [DATA_W-1:0] d, input logic [REF_W-1:0] hp);
    int   h = (int'(hp) < 2) ? 2 : int'(hp);
    bit   halves[$];
    exp_t e;
    halves.push_back(1'b0);
    halves.push_back(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      halves.push_back(d[i]);
      halves.push_back(!d[i]);
    end
`ifdef MANCHESTER_TX_PARITY_EN
    halves.push_back(^d);
    halves.push_back(!(^d));
`endif
    for (int i = 0; i < 2 * IDLE_BITS; i++) halves.push_back(1'b0);
    foreach (halves[k]) begin
      for (int r = 0; r < h; r++) begin
        e = '{man: halves[k], busy: 1'b1, done: 1'b0, ready: 1'b0};
        exp_q.push_back(e);
      end
    end
    e = exp_q.pop_back();
    e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Predictor: on each edge, reset aborts; an offer during an idle cycle is accepted.
  initial begin
    forever begin
      @(posedge clk);
      if (globalReset === 1'b1) begin
        exp_q.delete();
      end else if (last_was_idle && tx_if.txValid === 1'b1) begin
        push_frame(tx_if.txData, tx_if.halfPeriod);
        accepts++;
      end
    end
  end

  // Monitor: one comparison of {manOut, busy, frameDone, txReady} per cycle.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last_was_idle = 1'b0;
      end else begin
        e = '{man: 1'b0, busy: 1'b0, done: 1'b0, ready: !globalReset};
        last_was_idle = 1'b1;
      end
      got = {manOut, busy, frameDone, tx_if.txReady};
      if (mon_en) begin
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t {man,busy,done,ready} actual=%b required=%b",
                   $time, got, e);
        end
      end
    end
  end

  task automatic wait_accept();
    int start = accepts;
    int n = 0;
    while (accepts == start && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (accepts == start) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout actual=no accept required=accept within %0d cycles", BUDGET);
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [REF_W-1:0] hp);
    tx_if.txData     = d;
    tx_if.halfPeriod = hp;
    tx_if.txValid    = 1'b1;
    wait_accept();
    tx_if.txValid    = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !last_was_idle) && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout actual=%0d pending samples required=0", exp_q.size());
    end
  endtask

  initial begin
    globalReset      = 1'b1;
    tx_if.txValid    = 1'b0;
    tx_if.txData     = '0;
    tx_if.halfPeriod = 4'd8;

    // Reset for 10 cycles, checking outputs from the third reset cycle on.
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (8) @(posedge clk);
    #1 globalReset = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Single frame, H=8, A5.
    send(8'hA5, 4'd8);
    wait_idle();

    // Degenerate half periods are raised to 2.
    send(8'h3C, 4'd0);
    wait_idle();
    send(8'hC3, 4'd1);
    wait_idle();

    // Half period changes after accept must not affect the frame in flight.
    send(8'h96, 4'd8);
    tx_if.halfPeriod = 4'd4;
    tx_if.txData     = 8'h00;
    wait_idle();

    // txValid held high across two frames.
    tx_if.txData     = 8'hFF;
    tx_if.halfPeriod = 4'd8;
    tx_if.txValid    = 1'b1;
    wait_accept();
    tx_if.txData     = 8'h00;
    wait_accept();
    tx_if.txValid    = 1'b0;
    wait_idle();

    // Reset in the middle of data bit 3, then a clean frame.
    send(8'h5A, 4'd8);
    repeat (68) @(posedge clk);
    #1 globalReset = 1'b1;
    @(posedge clk);
    #1 globalReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h81, 4'd3);
    wait_idle();

    // Low-weight payload at H=4 (parity bit is 1 when compiled in).
    send(8'h07, 4'd4);
    wait_idle();

    // Randomised frames, sometimes back-to-back with valid held.
    for (int i = 0; i < 14; i++) begin
      logic [DATA_W-1:0] d;
      logic [REF_W-1:0]  hp;
      d  = DATA_W'($urandom);
      hp = REF_W'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) begin
        tx_if.txData     = d;
        tx_if.halfPeriod = hp;
        tx_if.txValid    = 1'b1;
        wait_accept();
        tx_if.txData     = DATA_W'($urandom);
        tx_if.halfPeriod = REF_W'($urandom_range(0, 9));
        wait_accept();
        tx_if.txValid    = 1'b0;
      end else begin
        send(d, hp);
        repeat ($urandom_range(0, 40)) begin
          @(posedge clk);
          #1 tx_if.txValid = ($urandom_range(0, 3) == 0);
        end
        tx_if.txValid = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
